// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: FSM state encoding and port addresses.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam logic [1:0] PORT0        = 2'd0;
  localparam logic [1:0] PORT1        = 2'd1;
  localparam logic [1:0] PORT2        = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: decodes the header, waits for
// the destination FIFO and sequences header, payload, parity and parity check.
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [1:0] dest
);

  state_t     state;
  state_t     state_next;
  logic [1:0] empty_sel;
  logic       emp;
  logic       soft_rst;
  logic       hdr_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DECODE_ADDRESS;
      dest  <= PORT0;
    end else begin
      state <= state_next;
      if (state == DECODE_ADDRESS && hdr_ok)
        dest <= data_in;
    end
  end

  // The header address is only meaningful in DECODE_ADDRESS; afterwards the
  // latched destination selects the empty flag.
  always_comb begin
    empty_sel = (state == DECODE_ADDRESS) ? data_in : dest;
    hdr_ok    = pkt_valid && (data_in != ADDR_INVALID);

    case (empty_sel)
      PORT0:   emp = fifo_empty_0;
      PORT1:   emp = fifo_empty_1;
      PORT2:   emp = fifo_empty_2;
      default: emp = 1'b0;
    endcase

    case (dest)
      PORT0:   soft_rst = soft_reset_0;
      PORT1:   soft_rst = soft_reset_1;
      PORT2:   soft_rst = soft_reset_2;
      default: soft_rst = 1'b0;
    endcase
  end

  // Soft reset of the current destination overrides every transition.
  always_comb begin
    state_next = state;
    if (state != DECODE_ADDRESS && soft_rst) begin
      state_next = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (hdr_ok)
            state_next = emp ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        WAIT_TILL_EMPTY: begin
          if (emp)
            state_next = LOAD_FIRST_DATA;
        end
        LOAD_FIRST_DATA: state_next = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)
            state_next = FIFO_FULL_STATE;
          else if (!pkt_valid)
            state_next = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full)
            state_next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)
            state_next = DECODE_ADDRESS;
          else if (low_pkt_valid)
            state_next = LOAD_PARITY;
          else
            state_next = LOAD_DATA;
        end
        LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: state_next = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: the driver queues the hand-derived state and
// destination for every cycle, a negedge monitor pops and compares the outputs.
module tb_router_fsm;
  import router_pkg::*;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       busy;
  logic [1:0] dest;

  typedef struct {
    state_t     st;
    logic [1:0] d;
  } expect_t;

  expect_t expQ[$];
  int      checks = 0;
  int      errors = 0;

  router_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .dest(dest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Output bundle order: detect,lfd,ld,laf,full,write_enb,rst_int,busy,dest[1:0].
  function automatic logic [9:0] expOut(input state_t st, input logic [1:0] d);
    logic [7:0] s;
    case (st)
      DECODE_ADDRESS:     s = 8'b1000_0000;
      LOAD_FIRST_DATA:    s = 8'b0100_0001;
      LOAD_DATA:          s = 8'b0010_0100;
      LOAD_PARITY:        s = 8'b0000_0101;
      FIFO_FULL_STATE:    s = 8'b0000_1001;
      LOAD_AFTER_FULL:    s = 8'b0001_0101;
      WAIT_TILL_EMPTY:    s = 8'b0000_0001;
      CHECK_PARITY_ERROR: s = 8'b0000_0011;
      default:            s = 8'b0000_0000;
    endcase
    return {s, d};
  endfunction

  function automatic logic [9:0] actOut();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy, dest};
  endfunction

  task automatic checkOutput(input string tag, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b required=%b", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected during this cycle.
  task automatic applyStimulus(input logic pv, input logic [1:0] din, input logic ff,
                               input logic pd, input logic lpv, input logic [2:0] sr,
                               input logic [2:0] fe, input state_t expState,
                               input logic [1:0] expDest);
    expect_t e;
    pkt_valid     = pv;
    data_in       = din;
    fifo_full     = ff;
    parity_done   = pd;
    low_pkt_valid = lpv;
    {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = fe;
    e.st = expState;
    e.d  = expDest;
    expQ.push_back(e);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      checkOutput(e.st.name(), actOut(), expOut(e.st, e.d));
    end
  end

  initial begin
    reset = 1'b1;
    pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    {soft_reset_2, soft_reset_1, soft_reset_0} = 3'b000;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = 3'b111;
    #2;
    checkOutput("reset_state", actOut(), expOut(DECODE_ADDRESS, 2'd0));
    #10 reset = 1'b0;
    @(posedge clock);
    #1;

    // Packet to port 2, destination empty, 4 valid cycles then parity.
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 0);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 3'b111, LOAD_FIRST_DATA, 2);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 3'b111, LOAD_DATA, 2);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 3'b111, LOAD_DATA, 2);
    applyStimulus(0, 2, 0, 0, 0, 3'b000, 3'b111, LOAD_DATA, 2);
    applyStimulus(0, 2, 0, 0, 0, 3'b000, 3'b111, LOAD_PARITY, 2);
    applyStimulus(0, 2, 0, 0, 0, 3'b000, 3'b111, CHECK_PARITY_ERROR, 2);
    applyStimulus(0, 2, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 2);

    // Packet to port 1 waiting for its FIFO to drain.
    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b101, DECODE_ADDRESS, 2);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b101, WAIT_TILL_EMPTY, 1);
    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b111, WAIT_TILL_EMPTY, 1);
    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b111, LOAD_FIRST_DATA, 1);

    // FIFO full for 3 cycles, then resume payload.
    applyStimulus(1, 1, 1, 0, 0, 3'b000, 3'b111, LOAD_DATA, 1);
    applyStimulus(1, 1, 1, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 1);
    applyStimulus(1, 1, 1, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 1);
    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 1);
    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b111, LOAD_AFTER_FULL, 1);

    // Full again, low_pkt_valid steers to parity.
    applyStimulus(1, 1, 1, 0, 0, 3'b000, 3'b111, LOAD_DATA, 1);
    applyStimulus(1, 1, 1, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 1);
    applyStimulus(1, 1, 1, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 1);
    applyStimulus(0, 1, 0, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 1);
    applyStimulus(0, 1, 0, 0, 1, 3'b000, 3'b111, LOAD_AFTER_FULL, 1);
    applyStimulus(0, 1, 0, 0, 0, 3'b000, 3'b111, LOAD_PARITY, 1);
    applyStimulus(0, 1, 0, 0, 0, 3'b000, 3'b111, CHECK_PARITY_ERROR, 1);

    // Port 0: full together with pkt_valid low, then parity_done wins.
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 1);
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b111, LOAD_FIRST_DATA, 0);
    applyStimulus(0, 0, 1, 0, 0, 3'b000, 3'b111, LOAD_DATA, 0);
    applyStimulus(0, 0, 1, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 0);
    applyStimulus(0, 0, 1, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 0);
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 0);
    applyStimulus(0, 0, 0, 1, 1, 3'b000, 3'b111, LOAD_AFTER_FULL, 0);

    // Invalid address 3 is dropped.
    applyStimulus(1, 3, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 0);
    applyStimulus(1, 3, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 0);
    applyStimulus(0, 3, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 0);

    // Soft resets: other port ignored, own port wins over fifo_full.
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 0);
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b111, LOAD_FIRST_DATA, 0);
    applyStimulus(1, 0, 0, 0, 0, 3'b010, 3'b111, LOAD_DATA, 0);
    applyStimulus(1, 0, 1, 0, 0, 3'b001, 3'b111, LOAD_DATA, 0);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 3'b011, DECODE_ADDRESS, 0);
    applyStimulus(1, 2, 0, 0, 0, 3'b101, 3'b011, WAIT_TILL_EMPTY, 2);
    applyStimulus(0, 2, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 2);

    // Full in CHECK_PARITY_ERROR re-enters FIFO_FULL_STATE.
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 2);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 3'b111, LOAD_FIRST_DATA, 2);
    applyStimulus(0, 2, 0, 0, 0, 3'b000, 3'b111, LOAD_DATA, 2);
    applyStimulus(0, 2, 0, 0, 0, 3'b000, 3'b111, LOAD_PARITY, 2);
    applyStimulus(0, 2, 1, 0, 0, 3'b000, 3'b111, CHECK_PARITY_ERROR, 2);
    applyStimulus(0, 2, 0, 0, 0, 3'b000, 3'b111, FIFO_FULL_STATE, 2);
    applyStimulus(0, 2, 0, 1, 0, 3'b000, 3'b111, LOAD_AFTER_FULL, 2);
    applyStimulus(0, 2, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 2);

    // Asynchronous reset in the middle of a payload.
    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 2);
    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b111, LOAD_FIRST_DATA, 1);
    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b111, LOAD_DATA, 1);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", actOut(), expOut(DECODE_ADDRESS, 2'd0));
    pkt_valid = 1'b0;
    #3 reset = 1'b0;
    @(posedge clock);
    #1;
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b111, DECODE_ADDRESS, 0);

    repeat (2) @(posedge clock);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain actual=%0d required=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
